// File: rtl/wb_regfile_pkg.sv
// Shared MIPS constants and types for the write-back / register-file slice.
// Exports: REG_ADDR_W, DATA_W, NUM_REGS, REG_ZERO, NUM_RD_PORTS, reg_addr_t, data_t.
package wb_regfile_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int DATA_W       = 32;
  localparam int NUM_REGS     = 32;
  localparam int NUM_RD_PORTS = 2;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;
endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB / decode stages and the register file.
// master: pipeline side (drives write-back inputs and read addresses).
// slave : register file (returns read data, write-back value, write strobe, count).
interface wb_regfile_if;
  import wb_regfile_pkg::*;
  logic      reg_wr_i;
  logic      mem_to_reg_i;
  reg_addr_t rd_i;
  data_t     res_alu_i;
  data_t     read_data_i;
  reg_addr_t rs_addr_i;
  reg_addr_t rt_addr_i;
  data_t     rs_data_o;
  data_t     rt_data_o;
  data_t     wb_data_o;
  logic      wb_we_o;
  data_t     wb_count_o;

  modport master (
    output reg_wr_i, mem_to_reg_i, rd_i, res_alu_i, read_data_i, rs_addr_i, rt_addr_i,
    input  rs_data_o, rt_data_o, wb_data_o, wb_we_o, wb_count_o
  );
  modport slave (
    input  reg_wr_i, mem_to_reg_i, rd_i, res_alu_i, read_data_i, rs_addr_i, rt_addr_i,
    output rs_data_o, rt_data_o, wb_data_o, wb_we_o, wb_count_o
  );
endinterface

// File: rtl/wb_regfile_core.sv
// mips_regfile_core: 32x32 register storage, one write port, NUM_RD_PORTS
// combinational read ports with write-first bypass. r0 is hardwired to 0.
// Ports: clk, reset (async high), we_i/waddr_i/wdata_i (write),
//        raddr_i[p] -> rdata_o[p] (reads).
module mips_regfile_core
  import wb_regfile_pkg::*;
(
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         we_i,
  input  reg_addr_t                                    waddr_i,
  input  data_t                                        wdata_i,
  input  logic [NUM_RD_PORTS-1:0][REG_ADDR_W-1:0]      raddr_i,
  output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]          rdata_o
);
  data_t regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != REG_ZERO) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads are gated to 0 during reset so the bypass cannot leak write data
  // while storage is held clear. r0 is never bypassed.
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    always_comb begin
      rdata_o[p] = '0;
      if (!reset && raddr_i[p] != REG_ZERO) begin
        if (we_i && raddr_i[p] == waddr_i) rdata_o[p] = wdata_i;
        else                               rdata_o[p] = regs_q[raddr_i[p]];
      end
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage mux, effective-write decode, write counter,
// and the register file core.
// Ports: clk, reset (async high), bus (wb_regfile_if.slave).
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);
  data_t wb_data;
  logic  wb_we;
  data_t wb_count_q, wb_count_d;

  assign wb_data = bus.mem_to_reg_i ? bus.read_data_i : bus.res_alu_i;
  // Writes to r0 are dropped here so the counter only sees real writes.
  assign wb_we   = bus.reg_wr_i && (bus.rd_i != REG_ZERO);

  // Wraps naturally at 2^32.
  assign wb_count_d = wb_we ? wb_count_q + 32'd1 : wb_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_count_q <= '0;
    else       wb_count_q <= wb_count_d;
  end

  logic [NUM_RD_PORTS-1:0][REG_ADDR_W-1:0] raddr;
  logic [NUM_RD_PORTS-1:0][DATA_W-1:0]     rdata;

  assign raddr[0] = bus.rs_addr_i;
  assign raddr[1] = bus.rt_addr_i;

  mips_regfile_core u_core (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wb_we),
    .waddr_i (bus.rd_i),
    .wdata_i (wb_data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign bus.rs_data_o  = rdata[0];
  assign bus.rt_data_o  = rdata[1];
  assign bus.wb_data_o  = wb_data;
  assign bus.wb_we_o    = wb_we;
  assign bus.wb_count_o = wb_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an array/counter reference model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic reset;
  wb_regfile_if bus();

  wb_regfile dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic        m_rst;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_wb();
    return bus.mem_to_reg_i ? bus.read_data_i : bus.res_alu_i;
  endfunction

  function automatic logic m_we();
    return bus.reg_wr_i && (bus.rd_i != 5'd0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (m_rst || a == 5'd0) return 32'd0;
    if (m_we() && a == bus.rd_i) return m_wb();
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.reg_wr_i = we; bus.mem_to_reg_i = m2r; bus.rd_i = rd;
    bus.res_alu_i = alu; bus.read_data_i = mem;
    bus.rs_addr_i = rs; bus.rt_addr_i = rt;
  endtask

  task automatic check_comb(input string tag);
    chk({tag, ":rs"},  bus.rs_data_o,  m_rd(bus.rs_addr_i));
    chk({tag, ":rt"},  bus.rt_data_o,  m_rd(bus.rt_addr_i));
    chk({tag, ":wbd"}, bus.wb_data_o,  m_wb());
    chk({tag, ":we"},  {31'd0, bus.wb_we_o}, {31'd0, m_we()});
    chk({tag, ":cnt"}, bus.wb_count_o, m_cnt);
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle(input string tag);
    #1 check_comb(tag);
    @(posedge clk);
    if (!m_rst && m_we()) begin
      m_regs[bus.rd_i] = m_wb();
      m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    m_clear();
    m_rst = 1'b1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0; m_rst = 1'b0;

    // All registers read 0 after reset.
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      #1;
      chk("rst_rs", bus.rs_data_o, 32'd0);
      chk("rst_rt", bus.rt_data_o, 32'd0);
    end
    chk("rst_cnt", bus.wb_count_o, 32'd0);
    @(negedge clk);

    // ALU write to r5, then read.
    drive(1, 0, 5, 32'h1234_5678, 32'h0, 0, 0);
    cycle("w5");
    drive(0, 0, 0, 0, 0, 5, 0);
    #1 chk("r5", bus.rs_data_o, 32'h1234_5678);
    chk("r5_cnt", bus.wb_count_o, 32'd1);
    @(negedge clk);

    // Memory write to r9 with both ports bypassing before the edge.
    drive(1, 1, 9, 32'h0BAD_0BAD, 32'hDEAD_BEEF, 9, 9);
    #1 chk("byp_rs", bus.rs_data_o, 32'hDEAD_BEEF);
    chk("byp_rt", bus.rt_data_o, 32'hDEAD_BEEF);
    cycle("w9");

    // Write attempt to r0.
    drive(1, 0, 0, 32'hFFFF_FFFF, 32'h0, 0, 0);
    #1 chk("r0_pre", bus.rs_data_o, 32'd0);
    chk("r0_we", {31'd0, bus.wb_we_o}, 32'd0);
    cycle("w0");
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_post", bus.rs_data_o, 32'd0);
    chk("r0_cnt", bus.wb_count_o, 32'd2);
    @(negedge clk);

    // Random traffic, reads biased toward the write address.
    for (int k = 0; k < 400; k++) begin
      logic [4:0] rd, rs, rt;
      rd = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd,
            $urandom, $urandom, rs, rt);
      cycle("rnd");
    end

    // Async reset mid-cycle discards prior writes.
    drive(1, 0, 31, 32'hA5A5_A5A5, 32'h0, 0, 31);
    cycle("w31");
    drive(0, 0, 0, 0, 0, 31, 31);
    #1 chk("r31", bus.rt_data_o, 32'hA5A5_A5A5);
    @(posedge clk);
    #2 reset = 1'b1;
    m_rst = 1'b1; m_clear();
    #1 chk("arst_rt", bus.rt_data_o, 32'd0);
    chk("arst_cnt", bus.wb_count_o, 32'd0);
    @(negedge clk);
    // Writes blocked and reads 0 while reset held.
    drive(1, 0, 3, 32'h5555_AAAA, 32'h0, 3, 31);
    cycle("inrst");
    reset = 1'b0; m_rst = 1'b0;
    // First edge after release writes normally.
    drive(1, 1, 3, 32'h0, 32'h7777_1111, 0, 0);
    cycle("post_rst");
    drive(0, 0, 0, 0, 0, 3, 31);
    cycle("post_rd");

    // Counter wrap via backdoor.
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1 release dut.wb_count_q;
    m_cnt = 32'hFFFF_FFFF;
    drive(1, 0, 7, 32'h0000_0042, 32'h0, 7, 0);
    cycle("wrap");
    drive(0, 0, 0, 0, 0, 7, 0);
    #1 chk("wrap_cnt", bus.wb_count_o, 32'd0);
    chk("wrap_r7", bus.rs_data_o, 32'h0000_0042);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
